// File: rtl/sms23_17_inv_seq.sv
// rtl/sms23_17_inv_seq.sv - iterative GF(2^6) x^26 sequencer (inverse of the x^17 S-box), build macro SMS23_INV_OVERLAP_EN
// Outer field: polynomial basis GF(2^6) mod x^6 + x + 1.
// Inner arithmetic: GF((2^2)^3), GF(4) = {0,1,w,w^2} with w^2 = w + 1, cubic extension z^3 = w.
// Composite element bits: [5:4] = z^2 coeff, [3:2] = z coeff, [1:0] = const coeff, each GF(4) as {w, 1}.
// The basis change maps the polynomial root x to beta = 1 + z + z^2, which satisfies beta^6 = beta + 1.

module sms23_17_inv_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] x,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] y,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Low four bits of the exponent 26 = 5'b11010; the leading 1 is the initial acc = base.
  localparam logic [3:0] EXP_BITS = 4'b1010;
  localparam logic [5:0] GF64_ONE = 6'b000001;

  // GF(4) multiply: (a1 w + a0)(b1 w + b0) reduced with w^2 = w + 1.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    gf4_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
               (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // GF(4) square: Frobenius, swaps w and w^2.
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    gf4_sq = {a[1], a[1] ^ a[0]};
  endfunction

  // GF(4) multiply by the constant w.
  function automatic logic [1:0] gf4_mulw(input logic [1:0] a);
    gf4_mulw = {a[1] ^ a[0], a[1]};
  endfunction

  // Polynomial basis -> composite basis; columns are beta^0 .. beta^5.
  function automatic logic [5:0] iso(input logic [5:0] v);
    iso = {v[3] ^ v[4],
           v[1] ^ v[2] ^ v[4],
           v[2] ^ v[4] ^ v[5],
           v[1] ^ v[3],
           v[5],
           v[0] ^ v[1] ^ v[2] ^ v[4] ^ v[5]};
  endfunction

  // Composite basis -> polynomial basis; exact inverse of iso().
  function automatic logic [5:0] inv_iso(input logic [5:0] c);
    inv_iso = {c[1],
               c[1] ^ c[2] ^ c[3] ^ c[4] ^ c[5],
               c[1] ^ c[2] ^ c[3] ^ c[4],
               c[2] ^ c[4] ^ c[5],
               c[1] ^ c[3] ^ c[4],
               c[0] ^ c[1] ^ c[4]};
  endfunction

  // Composite square: (a0 + a1 z + a2 z^2)^2 = a0^2 + w a2^2 z + a1^2 z^2.
  function automatic logic [5:0] gf64_sq(input logic [5:0] a);
    gf64_sq = {gf4_sq(a[3:2]), gf4_mulw(gf4_sq(a[5:4])), gf4_sq(a[1:0])};
  endfunction

  // Composite multiply: schoolbook over GF(4), z^3 = w and z^4 = w z fold the high terms.
  function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
    logic [1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    p00 = gf4_mul(a[1:0], b[1:0]);
    p01 = gf4_mul(a[1:0], b[3:2]);
    p02 = gf4_mul(a[1:0], b[5:4]);
    p10 = gf4_mul(a[3:2], b[1:0]);
    p11 = gf4_mul(a[3:2], b[3:2]);
    p12 = gf4_mul(a[3:2], b[5:4]);
    p20 = gf4_mul(a[5:4], b[1:0]);
    p21 = gf4_mul(a[5:4], b[3:2]);
    p22 = gf4_mul(a[5:4], b[5:4]);
    gf64_mul = {p02 ^ p11 ^ p20,
                p01 ^ p10 ^ gf4_mulw(p22),
                p00 ^ gf4_mulw(p12 ^ p21)};
  endfunction

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] acc_q, acc_d;
  logic [5:0] base_q, base_d;
  logic [5:0] y_q, y_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;

  logic [5:0] x_iso;
  logic [5:0] acc_sq;
  logic [5:0] mul_b;
  logic [5:0] acc_step;
  logic [5:0] y_step;
  logic       accept;

  // Single squarer and single multiplier shared across all four exponent steps.
  always_comb begin
    x_iso    = iso(x);
    acc_sq   = gf64_sq(acc_q);
    mul_b    = EXP_BITS[2'd3 - cnt_q] ? base_q : GF64_ONE;
    acc_step = gf64_mul(acc_sq, mul_b);
    y_step   = inv_iso(acc_step);
  end

`ifdef SMS23_INV_OVERLAP_EN
  // A retiring result frees the datapath in the same cycle, so DONE can take a new operand.
  assign in_ready = in_ready_q | (out_valid_q & out_ready);
`else
  assign in_ready = in_ready_q;
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

  // Next-state and next-output logic for the IDLE/EXP/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    base_d      = base_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          base_d  = x_iso;
          acc_d   = x_iso;
          cnt_d   = 2'd0;
          state_d = S_EXP;
        end
      end
      S_EXP: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          y_d         = y_step;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            base_d  = x_iso;
            acc_d   = x_iso;
            cnt_d   = 2'd0;
            state_d = S_EXP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      acc_q       <= 6'd0;
      base_q      <= 6'd0;
      y_q         <= 6'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sms23_17_inv_seq.sv
// tb/tb_sms23_17_inv_seq.sv - directed-vector bench for sms23_17_inv_seq
module tb_sms23_17_inv_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] y;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

`ifdef SMS23_INV_OVERLAP_EN
  localparam int PERIOD = 5;
`else
  localparam int PERIOD = 6;
`endif

  sms23_17_inv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
  } vec_t;

  vec_t vecs [6];

  // Reference multiply in the polynomial basis, modulus x^6 + x + 1.
  function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] aa;
    r  = 6'd0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[5] ? ({aa[4:0], 1'b0} ^ 6'h03) : {aa[4:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [5:0] gpow(input logic [5:0] a, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < e; i++) r = gmul(r, a);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [5:0] xin, output logic [5:0] yout, output int lat);
    in_valid = 1'b1;
    x        = xin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    yout     = 6'h3f;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat  = k;
        yout = y;
        break;
      end
    end
  endtask

  initial begin
    logic [5:0] yr;
    int         lat;
    bit         seen [64];
    int         distinct;
    bit         bp_ok;
    int         stray;
    logic [5:0] xs [5];
    logic [5:0] exp_q [$];
    int         acc_i, got, last_cyc;
    logic       acc_now, ret_now;

    vecs[0] = '{x: 6'h01, y: 6'h01};
    vecs[1] = '{x: 6'h02, y: 6'h07};
    vecs[2] = '{x: 6'h03, y: 6'h33};
    vecs[3] = '{x: 6'h04, y: 6'h15};
    vecs[4] = '{x: 6'h20, y: 6'h10};
    vecs[5] = '{x: 6'h00, y: 6'h00};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 6'd0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_y", int'(y), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_in_ready", int'(in_ready), 1);

    // x = 0 accepted on the first edge after reset release.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_op(6'h00, yr, lat);
    check("zero_latency", lat, 5);
    check("zero_y", int'(yr), 0);
    @(negedge clk);
    check("zero_back_idle", int'({out_valid, busy, in_ready}), 1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, yr, lat);
      check("table_latency", lat, 5);
      check("table_y", int'(yr), int'(vecs[i].y));
      @(negedge clk);
      check("table_idle", int'({out_valid, busy, in_ready}), 1);
    end

    distinct = 0;
    for (int i = 0; i < 64; i++) begin
      run_op(6'(i), yr, lat);
      check("sweep_fwd_x17", int'(gpow(yr, 17)), i);
      check("sweep_y_x26", int'(yr), int'(gpow(6'(i), 26)));
      if (!seen[yr]) distinct++;
      seen[yr] = 1'b1;
      @(negedge clk);
    end
    check("sweep_distinct", distinct, 64);

    // Unbounded backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    run_op(6'h01, yr, lat);
    check("bp_latency", lat, 5);
    bp_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = k[0];
      x        = 6'h2a;
      @(negedge clk);
      if (!(out_valid && y == 6'h01 && !in_ready && busy)) bp_ok = 1'b0;
    end
    check("bp_hold_stable", int'(bp_ok), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_retired", int'({out_valid, busy}), 0);
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("bp_single_transfer", stray, 0);

    // Reset in the middle of an operation.
    run_op(6'h02, yr, lat);
    check("pre_reset_y", int'(yr), 7);
    @(negedge clk);
    in_valid = 1'b1;
    x        = 6'h03;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_op_busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_y", int'(y), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort_no_stale", stray, 0);
    run_op(6'h04, yr, lat);
    check("post_abort_latency", lat, 5);
    check("post_abort_y", int'(yr), 6'h15);
    @(negedge clk);

    // Streaming: continuous in_valid and out_ready.
    xs[0] = 6'h02; xs[1] = 6'h03; xs[2] = 6'h04; xs[3] = 6'h20; xs[4] = 6'h05;
    acc_i    = 0;
    got      = 0;
    last_cyc = -1;
    in_valid = 1'b1;
    x        = xs[0];
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      acc_now = in_valid && in_ready;
      ret_now = out_valid && out_ready;
      if (ret_now) begin
        if (exp_q.size() > 0) check("stream_y", int'(y), int'(exp_q.pop_front()));
        else check("stream_unexpected", 1, 0);
        if (last_cyc >= 0) check("stream_period", cyc - last_cyc, PERIOD);
        last_cyc = cyc;
        got++;
      end
      if (acc_now) begin
        exp_q.push_back(gpow(x, 26));
        acc_i++;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (acc_i < 5) x = xs[acc_i];
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_count", got, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sms23_17_inv_seq.md
SMS23_17_INV_SEQ -- requirements
Module: sms23_17_inv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  x carries an operand to invert.
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 x  input  6  operand, in the same polynomial-basis GF(2^6) representation as the forward x^17 S-box input.
REQ-007 out_valid  output  1  y holds a completed result.
REQ-008 out_ready  input  1  downstream consumes y this cycle.
REQ-009 y  output  6  result, polynomial basis.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 y SHALL equal x^26 in GF(2^6), so y is the unique value whose forward x^17 S-box image is x (17*26 = 1 mod 63).
REQ-012 Arithmetic SHALL run in the composite field GF((2^2)^3), using the team's existing basis-change, GF(4) multiply, GF(4) square and GF(4) constant-multiply helpers.
REQ-013 The block SHALL contain exactly one GF(2^6) multiplier and one squarer, used iteratively.
REQ-014 FSM states: IDLE, EXP, DONE.
REQ-015 IDLE: in_ready=1; on in_valid, capture base <= iso(x) and acc <= iso(x), clear cnt to 0, go to EXP.
REQ-016 EXP: each cycle, acc <= acc^2 * (e[3-cnt] ? base : 1) with e = 4'b1010 (trailing bits of 26 = 5'b11010), and cnt increments.
REQ-017 EXP exits to DONE on the edge where cnt = 3, after exactly 4 steps.
REQ-018 Progression of acc: w, w^3, w^6, w^13, w^26.
REQ-019 DONE: out_valid=1, y = inv_iso(acc) (registered or combinational from acc).
REQ-020 DONE: return to IDLE on out_ready.
REQ-021 Latency: accept in cycle T -> out_valid first high in cycle T+5.
REQ-022 y SHALL stay stable while out_valid=1 and out_ready=0; backpressure is unbounded.
REQ-023 in_valid SHALL be ignored whenever in_ready=0; operands are neither queued nor dropped silently, since in_ready deasserts.
REQ-024 x = 0 SHALL take the full 5-cycle path and yield y = 0; there is no early exit.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, cnt=0, acc=0, base=0, out_valid=0, y=0, busy=0, in_ready=1 (in_ready returns to 1 once rst_n deasserts).
REQ-027 Reset during EXP or DONE SHALL abort the operation with no result ever presented.
REQ-028 The first accept SHALL be possible in the first rising edge with rst_n high.

Configuration
REQ-029 Macro SMS23_INV_OVERLAP_EN defined: in DONE, in_ready = out_ready.
REQ-030 With SMS23_INV_OVERLAP_EN, in_valid & out_ready in DONE SHALL both retire the result and capture the new operand, going directly to EXP; this gives a throughput of 1 result per 5 cycles.
REQ-031 Macro SMS23_INV_OVERLAP_EN undefined: in_ready=1 only in IDLE; throughput is 1 result per 6 cycles.
REQ-032 Latency and results SHALL be identical in both builds.

Verification
REQ-033 Reset, then x=6'h00 with out_ready=1 -> out_valid in cycle T+5, y=6'h00, then IDLE.
REQ-034 Sweep x over all 64 values -> the forward x^17 S-box of each y returns x; all 64 y values are distinct.
REQ-035 Accept x=6'h01, hold out_ready=0 for 20 cycles -> y stable, in_ready=0 throughout, in_valid pulses ignored; release -> one transfer only.
REQ-036 Assert rst_n=0 in cycle T+2 of an operation -> out_valid=0, y=6'h00, busy=0 at once; no stale result appears after reset release.
REQ-037 SMS23_INV_OVERLAP_EN build, continuous in_valid and out_ready -> one out_valid every 5 cycles with correct y; non-overlap build -> one every 6 cycles.
